add_64: RTL and testbench
=========================

# add_64

Pipelined signed adder tree that reduces 64 signed W-bit operands to a single W-bit sum with one result per clock. It is the accumulation stage of the binary-neural-net accelerator: a neuron feeds it 64 partial products or activations every cycle, and it returns the neuron's pre-activation sum a fixed number of cycles later.

## Interface
- W, default 19: width of each operand and of the result (signed, two's complement).
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in, input, 64 x W (unpacked array `[63:0]` of signed `[W-1:0]`): operands, sampled every rising edge.
- out, output, W: signed sum of the 64 operands captured 6 edges earlier.

## Operation
- Binary reduction tree with 6 registered levels: 64→32→16→8→4→2→1.
- Level k (k=1..6) register j holds the sum of level k-1 entries 2j and 2j+1. Level 0 is `in`, which is not registered.
- Internal arithmetic is exact:
  - Operands are sign-extended to W+6 bits (25 for W=19) before level 1.
  - Level k may be sized W+k bits, but no intermediate value may overflow.
- Output conversion from the exact (W+6)-bit sum to W bits is controlled by the configuration macro below.
- Conversion is combinational from the level-6 register, so `out` adds no register stage.
- No handshake. Every cycle is a valid input slot and throughput is 1 sum/cycle.
- Only `in` and `rst` influence the result.

## Timing
- Latency is exactly 6 rising edges. Operands present at edge t appear on `out` after edge t+5 and remain stable until edge t+6.
- Reset:
  - While `rst`=1 at an edge, every pipeline register is cleared to 0.
  - `out` therefore reads 0 after that edge.
  - Operands present during reset edges are discarded.
- After reset deassertion:
  - The first operands sampled with `rst`=0 reach `out` 6 edges later.
  - Until then `out` = 0.
- Reset mid-stream:
  - All in-flight sums are lost; no partial or stale sum ever appears after reset.
  - Deasserting reset for one cycle between reset pulses is legal.
- `out` is a glitch-free function of the level-6 register (combinational decode only) and changes only after clock edges.
- Sign behaviour: all operands are signed. For example, 64 × −1 = −64. There is no unsigned mode.

## Configuration
- Macro: `ADD64_SATURATE_EN`.
- Defined:
  - If the exact sum is > 2^(W-1)−1, `out` = 2^(W-1)−1 (262143 for W=19).
  - If the exact sum is < −2^(W-1), `out` = −2^(W-1) (−262144).
  - Otherwise `out` equals the sum.
- Undefined (default):
  - `out` = the low W bits of the exact sum, i.e. wrap modulo 2^W.
  - No saturation logic is synthesized.
- Latency is 6 cycles in both builds.

## Test plan
- Reset then uniform operands:
  - Hold `rst`=1 for 2 edges, then release.
  - Set all 64 `in` = −2 from the first edge after release.
  - Required: `out` = 0 for 5 edges after release, then `out` = −128 from the 6th edge onward.
- Ramp throughput:
  - Drive `in[i]` = i in cycle 0, `in[i]` = −i in cycle 1, all 0 in cycle 2.
  - Required: `out` = 2016, −2016, 0 on three consecutive cycles starting 6 edges after cycle 0.
- Positive overflow, all `in` = 262143:
  - Without macro: `out` = −64.
  - With `ADD64_SATURATE_EN`: `out` = 262143.
- Negative overflow, all `in` = −262144:
  - Without macro: `out` = 0.
  - With macro: `out` = −262144.
- Reset mid-stream:
  - Stream random operands, then assert `rst` for 1 edge at cycle 3 of the stream.
  - Required: `out` = 0 starting at the edge where `rst` was sampled high, and staying 0 until 6 edges after the first post-reset input.
  - No pre-reset sum ever appears.
- Mixed signs, single pair per operand:
  - Set `in[0]` = 262143, `in[1]` = −262144, all others 0.
  - Required: `out` = −1 after 6 edges in both builds.

Source files
------------

// File: rtl/add_64_if.sv
// Operand/result bundle for the 64-input signed adder tree.
// The tree drives out; the producer drives the 64 operands in.
interface add_64_if #(
    parameter int W = 19
);
    logic signed [W-1:0] in [63:0];
    logic signed [W-1:0] out;

    modport master (output in, input out);
    modport slave (input in, output out);
endinterface

// File: rtl/add_64.sv
// Six-level pipelined signed adder tree: 64 W-bit operands -> one W-bit sum per clock.
// Build option ADD64_SATURATE_EN clamps the result; otherwise the sum wraps modulo 2^W.
module add_64 #(
    parameter int W = 19
) (
    input  logic     clk,
    input  logic     rst,
    add_64_if.slave  bus
);
    // Every level is carried at the full W+6 width so no stage can overflow.
    typedef logic signed [W+5:0] acc_t;

    localparam acc_t ACC_ZERO = {(W+6){1'b0}};

    function automatic acc_t sext(input logic signed [W-1:0] v);
        return {{6{v[W-1]}}, v};
    endfunction

    acc_t lvl1_r [0:31];
    acc_t lvl2_r [0:15];
    acc_t lvl3_r [0:7];
    acc_t lvl4_r [0:3];
    acc_t lvl5_r [0:1];
    acc_t lvl6_r;

    logic signed [W-1:0] out_s;

    // Reduction pipeline: each level sums adjacent pairs of the level below.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 32; j++) lvl1_r[j] <= ACC_ZERO;
            for (int j = 0; j < 16; j++) lvl2_r[j] <= ACC_ZERO;
            for (int j = 0; j < 8; j++)  lvl3_r[j] <= ACC_ZERO;
            for (int j = 0; j < 4; j++)  lvl4_r[j] <= ACC_ZERO;
            for (int j = 0; j < 2; j++)  lvl5_r[j] <= ACC_ZERO;
            lvl6_r <= ACC_ZERO;
        end else begin
            for (int j = 0; j < 32; j++) lvl1_r[j] <= sext(bus.in[2*j]) + sext(bus.in[2*j+1]);
            for (int j = 0; j < 16; j++) lvl2_r[j] <= lvl1_r[2*j] + lvl1_r[2*j+1];
            for (int j = 0; j < 8; j++)  lvl3_r[j] <= lvl2_r[2*j] + lvl2_r[2*j+1];
            for (int j = 0; j < 4; j++)  lvl4_r[j] <= lvl3_r[2*j] + lvl3_r[2*j+1];
            for (int j = 0; j < 2; j++)  lvl5_r[j] <= lvl4_r[2*j] + lvl4_r[2*j+1];
            lvl6_r <= lvl5_r[0] + lvl5_r[1];
        end
    end

`ifdef ADD64_SATURATE_EN
    localparam acc_t SAT_MAX = {{7{1'b0}}, {(W-1){1'b1}}};
    localparam acc_t SAT_MIN = {{7{1'b1}}, {(W-1){1'b0}}};

    // Clamp the exact sum into the signed W-bit range.
    always_comb begin
        out_s = lvl6_r[W-1:0];
        if (lvl6_r > SAT_MAX) begin
            out_s = SAT_MAX[W-1:0];
        end else if (lvl6_r < SAT_MIN) begin
            out_s = SAT_MIN[W-1:0];
        end else begin
            out_s = lvl6_r[W-1:0];
        end
    end
`else
    // Wrap mode keeps only the low W bits; the guard bits are intentionally dropped.
    logic unused_hi_s;
    assign unused_hi_s = ^lvl6_r[W+5:W];

    // Truncate the exact sum to W bits (modulo 2^W).
    always_comb begin
        out_s = lvl6_r[W-1:0];
    end
`endif

    assign bus.out = out_s;

endmodule

// File: tb/tb_add_64.sv
// Self-checking bench for add_64: directed cases plus random streams against
// a history-based model (sum of inputs 5 edges back, zero if any reset in the window).
module tb_add_64;
    localparam int W = 19;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    int      ops [64];
    longint  hist_sum [$];
    bit      hist_rst [$];

    add_64_if #(.W(W)) bus ();

    add_64 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Convert the exact integer sum to the W-bit result of the selected build.
    function automatic longint conv(input longint s);
        logic signed [W-1:0] t;
`ifdef ADD64_SATURATE_EN
        if (s > 262143) return 262143;
        else if (s < -262144) return -262144;
        else return s;
`else
        t = s[W-1:0];
        return longint'(t);
`endif
    endfunction

    // Expected out after edge t: zero if any reset in edges t-5..t, else conv(sum at t-5).
    function automatic longint model(input int t);
        for (int k = 0; k < 6; k++) begin
            if (t - k < 0) return 0;
            if (hist_rst[t-k]) return 0;
        end
        return conv(hist_sum[t-5]);
    endfunction

    task automatic compare(input string tag, input longint exp);
        logic signed [W-1:0] e19;
        e19 = exp[W-1:0];
        tests++;
        assert (bus.out === e19) else begin
            fails++;
            $error("FAIL %s: out=%0d expected=%0d", tag, bus.out, e19);
        end
    endtask

    // Drive ops/rst, take one rising edge, record history, check against the model.
    task automatic tick(input bit r, input string tag);
        longint s;
        s = 0;
        rst = r;
        for (int i = 0; i < 64; i++) begin
            bus.in[i] = ops[i][W-1:0];
            s += longint'(ops[i]);
        end
        @(posedge clk);
        hist_sum.push_back(s);
        hist_rst.push_back(r);
        #1;
        compare(tag, model(hist_sum.size() - 1));
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 64; i++) ops[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(3) == 0) ops[i] = ($urandom_range(1) == 0) ? 262143 : -262144;
            else ops[i] = int'($urandom) >>> 13;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        fill(0);

        // Reset for two edges, then all operands -2.
        tick(1'b1, "reset0");
        tick(1'b1, "reset1");
        compare("reset_out", 0);
        fill(-2);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, "uniform_fill");
            compare("uniform_zero", 0);
        end
        tick(1'b0, "uniform_first");
        compare("uniform_m128", -128);
        tick(1'b0, "uniform_hold");
        compare("uniform_hold", -128);

        // Ramp throughput: i, -i, 0 in consecutive cycles.
        for (int i = 0; i < 64; i++) ops[i] = i;
        tick(1'b0, "ramp_pos");
        for (int i = 0; i < 64; i++) ops[i] = -i;
        tick(1'b0, "ramp_neg");
        fill(0);
        for (int k = 0; k < 4; k++) tick(1'b0, "ramp_flush");
        compare("ramp_2016", 2016);
        tick(1'b0, "ramp_flush");
        compare("ramp_m2016", -2016);
        tick(1'b0, "ramp_flush");
        compare("ramp_zero", 0);

        // Positive overflow.
        fill(262143);
        tick(1'b0, "posovf_in");
        fill(0);
        for (int k = 0; k < 5; k++) tick(1'b0, "posovf_flush");
`ifdef ADD64_SATURATE_EN
        compare("posovf_result", 262143);
`else
        compare("posovf_result", -64);
`endif

        // Negative overflow.
        fill(-262144);
        tick(1'b0, "negovf_in");
        fill(0);
        for (int k = 0; k < 5; k++) tick(1'b0, "negovf_flush");
`ifdef ADD64_SATURATE_EN
        compare("negovf_result", -262144);
`else
        compare("negovf_result", 0);
`endif

        // Mixed signs in a single pair.
        ops[0] = 262143;
        ops[1] = -262144;
        tick(1'b0, "mixed_in");
        fill(0);
        for (int k = 0; k < 5; k++) tick(1'b0, "mixed_flush");
        compare("mixed_m1", -1);

        // Random stream with a one-edge reset at stream cycle 3.
        for (int k = 0; k < 3; k++) begin
            fill_random();
            tick(1'b0, "rand_pre");
        end
        fill_random();
        tick(1'b1, "rand_rst");
        compare("midrst_zero", 0);
        for (int k = 0; k < 5; k++) begin
            fill_random();
            tick(1'b0, "rand_post");
            compare("midrst_hold", 0);
        end
        for (int k = 0; k < 30; k++) begin
            fill_random();
            tick(1'b0, "rand_run");
        end

        // Reset pulses separated by a single released cycle.
        fill_random();
        tick(1'b1, "pulse_a");
        fill_random();
        tick(1'b0, "pulse_gap");
        compare("pulse_gap_zero", 0);
        fill_random();
        tick(1'b1, "pulse_b");
        for (int k = 0; k < 40; k++) begin
            fill_random();
            tick(1'b0, "rand_tail");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
